// File: rtl/usb_hs_pkg.sv
// Shared types and constants for the USB HS transmit path.
package usb_hs_pkg;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } tx_state_e;

    // Line states as {dp, dm}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;

    // Default field lengths
    localparam int SYNC_BITS_DEF = 32;
    localparam int EOP_BITS_DEF  = 8;
    localparam int STUFF_LEN_DEF = 6;

endpackage

// File: rtl/usb_nrzi_stuff.sv
// Bit-stuffing and NRZI line encoder. Tracks the run of transmitted ones,
// flags the slot in which a stuff bit must be inserted, and holds the
// current NRZI line level (1 = J, 0 = K).
module usb_nrzi_stuff
    import usb_hs_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bit_i,          // next bit to send (ignored in a stuff slot)
    input  logic       bit_valid_i,    // a bit slot follows this edge
    input  logic       stuff_en_i,     // stuffing/run counting active
    input  logic       nrzi_preset_i,  // return to J, clear run (line going idle)
    output logic [1:0] line_o,         // {dp, dm} for the current level
    output logic       stall_o         // next slot is a stuff bit
);

    localparam int OW = $clog2(STUFF_LEN + 1);

    logic [OW-1:0] ones_q, ones_d;
    logic          level_q, level_d;

    assign stall_o = stuff_en_i && (ones_q == OW'(STUFF_LEN));
    assign line_o  = level_q ? LS_J : LS_K;

    // Next run length and line level for the slot after this edge
    always_comb begin
        ones_d  = ones_q;
        level_d = level_q;
        if (nrzi_preset_i) begin
            ones_d  = '0;
            level_d = 1'b1;
        end else if (bit_valid_i) begin
            if (stall_o) begin
                // Inserted zero: toggle and restart the run
                ones_d  = '0;
                level_d = ~level_q;
            end else begin
                level_d = bit_i ? level_q : ~level_q;
                if (stuff_en_i)
                    ones_d = bit_i ? ones_q + OW'(1) : '0;
            end
        end
    end

    // Run counter and NRZI level registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ones_q  <= '0;
            level_q <= 1'b1;
        end else begin
            ones_q  <= ones_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/usb_hs_tx.sv
// USB HS serial transmitter: SYNC, LSB-first data with bit stuffing, NRZI,
// HS EOP. Optional feature macro: USB_HS_TX_CHIRP_EN (adds chirp_k input
// that drives K from IDLE).
module usb_hs_tx
    import usb_hs_pkg::*;
#(
    parameter int SYNC_BITS = SYNC_BITS_DEF,
    parameter int EOP_BITS  = EOP_BITS_DEF,
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic       clk_480m_usb,
    input  logic       rst,
`ifdef USB_HS_TX_CHIRP_EN
    input  logic       chirp_k,
`endif
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_enable,
    output logic       dp_bit_hs_phy,
    output logic       dm_bit_hs_phy,
    output logic       tx_busy
);

    localparam int CW = $clog2(SYNC_BITS + EOP_BITS + 8);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;     // SYNC/EOP bit index, or data bit index
    logic [6:0]    sr_q, sr_d;       // remaining bits of the current byte
    logic          bit_nxt, stall, load_pt, start;
    logic [1:0]    enc_line, line;
    logic          chirp_q, chirp_d;

`ifdef USB_HS_TX_CHIRP_EN
    assign start   = (state_q == IDLE) && tx_valid && !chirp_k;
    assign chirp_d = (state_q == IDLE) && chirp_k;
`else
    assign start   = (state_q == IDLE) && tx_valid;
    assign chirp_d = 1'b0;
`endif

    // Last slot of SYNC, or last slot of a byte (bit 7 or its trailing stuff bit)
    assign load_pt = ((state_q == SYNC) && (cnt_q == CW'(SYNC_BITS - 1))) ||
                     ((state_q == DATA) && (cnt_q == CW'(7)) && !stall);
    assign tx_ready = load_pt && tx_valid;

    // State, counter and shift registers
    always_ff @(posedge clk_480m_usb or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            chirp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            chirp_q <= chirp_d;
        end
    end

    // Next state: packet framing and load-point decisions
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SYNC;
            SYNC: if (load_pt) state_d = tx_valid ? DATA : EOP;
            DATA: if (load_pt) state_d = tx_valid ? DATA : EOP;
            EOP:  if (cnt_q == CW'(EOP_BITS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit selection for the next slot; stuff slots freeze the data path
    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bit_nxt = 1'b0;
        case (state_q)
            IDLE: cnt_d = '0;
            SYNC, DATA: begin
                if (load_pt) begin
                    cnt_d = '0;
                    if (tx_valid) begin
                        sr_d    = tx_data[7:1];
                        bit_nxt = tx_data[0];
                    end
                end else if (state_q == SYNC) begin
                    cnt_d   = cnt_q + CW'(1);
                    bit_nxt = (cnt_q == CW'(SYNC_BITS - 2));
                end else if (!stall) begin
                    cnt_d   = cnt_q + CW'(1);
                    sr_d    = {1'b0, sr_q[6:1]};
                    bit_nxt = sr_q[0];
                end
            end
            EOP: begin
                cnt_d   = cnt_q + CW'(1);
                bit_nxt = 1'b1;
            end
            default: cnt_d = '0;
        endcase
    end

    usb_nrzi_stuff #(.STUFF_LEN(STUFF_LEN)) u_enc (
        .clk_i         (clk_480m_usb),
        .rst_i         (rst),
        .bit_i         (bit_nxt),
        .bit_valid_i   (state_d != IDLE),
        .stuff_en_i    ((state_q == SYNC) || (state_q == DATA)),
        .nrzi_preset_i (state_d == IDLE),
        .line_o        (enc_line),
        .stall_o       (stall)
    );

    // Line outputs: encoder level while framing, chirp K or SE0 when idle
    always_comb begin
        line      = LS_SE0;
        tx_enable = 1'b0;
        if (state_q != IDLE) begin
            line      = enc_line;
            tx_enable = 1'b1;
        end else if (chirp_q) begin
            line      = LS_K;
            tx_enable = 1'b1;
        end
    end

    assign {dp_bit_hs_phy, dm_bit_hs_phy} = line;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_usb_hs_tx.sv
// Scoreboard bench for usb_hs_tx: packets are modelled as bit streams
// (SYNC + stuffed data + EOP, then NRZI) and compared per line cycle.
module tb_usb_hs_tx;
    import usb_hs_pkg::*;

    localparam int SB = 32;
    localparam int EB = 8;
    localparam int SL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_enable, dp, dm, tx_busy;
`ifdef USB_HS_TX_CHIRP_EN
    logic       chirp_k = 1'b0;
`endif

    usb_hs_tx dut (
        .clk_480m_usb  (clk),
        .rst           (rst),
`ifdef USB_HS_TX_CHIRP_EN
        .chirp_k       (chirp_k),
`endif
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_enable     (tx_enable),
        .dp_bit_hs_phy (dp),
        .dm_bit_hs_phy (dm),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_chk  = 0;
    logic [1:0] exp_line_q[$];
    int         exp_rdy_q[$];
    int         slot = 0;
    bit         in_chirp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: raw bits, stuffing over SYNC+data, raw EOP, then NRZI from J
    task automatic push_model(input logic [7:0] b[$]);
        bit raw[$];
        bit s[$];
        int run = 0;
        bit lvl = 1'b1;
        for (int i = 0; i < SB; i++) raw.push_back(i == SB - 1);
        foreach (b[k]) for (int j = 0; j < 8; j++) raw.push_back(b[k][j]);
        foreach (raw[i]) begin
            if (i >= SB && (i - SB) % 8 == 0) exp_rdy_q.push_back(s.size() - 1);
            s.push_back(raw[i]);
            run = raw[i] ? run + 1 : 0;
            if (run == SL) begin
                s.push_back(1'b0);
                run = 0;
            end
        end
        for (int i = 0; i < EB; i++) s.push_back(i != 0);
        foreach (s[i]) begin
            if (!s[i]) lvl = ~lvl;
            exp_line_q.push_back(lvl ? LS_J : LS_K);
        end
    endtask

    // Monitor: compares every line cycle and every tx_ready against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_ready) begin
                chk("ready_expected", exp_rdy_q.size() > 0, 1);
                if (exp_rdy_q.size() > 0) chk("ready_slot", slot, exp_rdy_q.pop_front());
            end
            if (tx_enable) begin
                chk("line_expected", exp_line_q.size() > 0, 1);
                if (exp_line_q.size() > 0) chk("line", {dp, dm}, exp_line_q.pop_front());
                slot++;
            end else begin
                slot = 0;
                chk("idle_se0", {dp, dm}, LS_SE0);
            end
            if (!in_chirp) chk("busy_vs_enable", tx_busy, tx_enable);
        end
    end

    task automatic wait_ready(output bit ok);
        int to = 0;
        ok = 1'b0;
        while (to < 400) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            to++;
        end
        chk("ready_wait", ok, 1);
    endtask

    task automatic send(input logic [7:0] b[$]);
        bit ok;
        int to = 0;
        push_model(b);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = b[0];
        foreach (b[k]) begin
            wait_ready(ok);
            if (!ok) begin
                tx_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (k + 1 < b.size()) tx_data = b[k + 1];
            else begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end
        end
        do begin
            @(negedge clk); #1;
            to++;
        end while (tx_busy && to < 400);
        chk("pkt_end_idle", tx_busy, 0);
        chk("line_q_drained", exp_line_q.size(), 0);
        chk("ready_q_drained", exp_rdy_q.size(), 0);
        exp_line_q.delete();
        exp_rdy_q.delete();
    endtask

    initial begin
        logic [7:0] q[$];
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_line", {dp, dm}, LS_SE0);
        chk("rst_enable", tx_enable, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_busy", tx_busy, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        q = {8'h00};                      send(q);
        q = {8'hFF, 8'h3F};               send(q);
        q = {8'hA5, 8'h5A, 8'hC3, 8'h3C}; send(q);
        q = {8'h12, 8'h34};               send(q);

        // Reset in the middle of the first data byte
        q = {8'h96, 8'h69};
        push_model(q);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        wait_ready(ok);
        @(posedge clk); #1;
        tx_data = 8'h69;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_line", {dp, dm}, LS_SE0);
        chk("midrst_enable", tx_enable, 0);
        chk("midrst_ready", tx_ready, 0);
        chk("midrst_busy", tx_busy, 0);
        exp_line_q.delete();
        exp_rdy_q.delete();
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        q = {8'h81};
        send(q);

        // Random packets, biased toward runs of ones
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, 5);
            q.delete();
            for (int i = 0; i < n; i++)
                q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send(q);
        end

`ifdef USB_HS_TX_CHIRP_EN
        // Chirp K for 100 cycles with ignored tx_valid pulses
        in_chirp = 1'b1;
        for (int i = 0; i < 100; i++) exp_line_q.push_back(LS_K);
        @(negedge clk);
        chirp_k = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 100) begin
                chirp_k  = 1'b0;
                tx_valid = 1'b0;
            end else begin
                tx_valid = (i % 17 == 5);
            end
        end
        @(negedge clk); #1;
        chk("chirp_end_se0", {dp, dm}, LS_SE0);
        chk("chirp_q_drained", exp_line_q.size(), 0);
        chk("chirp_no_ready", exp_rdy_q.size(), 0);
        chk("chirp_not_busy", tx_busy, 0);
        in_chirp = 1'b0;
        exp_line_q.delete();
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
